dem8bit_ctrl: RTL and testbench

Run/direction controller for the 8-bit up/down count datapath, used in the 1 Hz switch-driven counting demo. Divides the board clock into a 1 Hz tick and issues one-cycle `step` strobes with a registered `ud` direction to an enable-gated up/down counter. Handles run/stop, wrap modes, bounded ping-pong and a manual direction flip. Reads the counter value `q` back to decide turnarounds.

---
 rtl/dem_ctrl_pkg.sv | 20 ++
 rtl/dem8bit_ctrl_tick_gen.sv | 34 +++
 rtl/dem8bit_ctrl.sv | 95 +++++++++
 tb/tb_dem8bit_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dem_ctrl_pkg.sv
// Shared encodings for the 1 Hz up/down counting demo controller.
package dem_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN   = 2'b01,
    MODE_PP   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_t;

  localparam logic UD_UP = 1'b0;
  localparam logic UD_DN = 1'b1;

endpackage

// File: rtl/dem8bit_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every CLK_HZ/TICK_HZ cycles while enabled.
module tick_gen #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_pcnt;
  logic          r_tick;

  // tick is registered one count early so it is high exactly while pcnt == DIV-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else if (!en) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pcnt == PW'(DIV - 2));
      r_pcnt <= (r_pcnt == PW'(DIV - 1)) ? '0 : r_pcnt + PW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/dem8bit_ctrl.sv
// Run/direction controller: issues step/ud strobes to an up/down counter
// once per prescaler tick, with wrap, ping-pong and manual flip handling.
module dem8bit_ctrl
  import dem_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned N       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw_run,
  input  logic [1:0]   sw_mode,
  input  logic         btn_flip,
  input  logic [N-1:0] lo_lim,
  input  logic [N-1:0] hi_lim,
  input  logic [N-1:0] q,
  output logic         step,
  output logic         ud,
  output logic [1:0]   state,
  output logic         tick,
  output logic         err
);

  state_t r_state, w_state_nx, w_cur;
  logic   r_step, r_ud, r_err;
  logic   w_step_nx, w_ud_nx, w_err_nx, w_d, w_tick;
  mode_t  w_mode;

  assign w_mode = mode_t'(sw_mode);

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (sw_run),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STOP;
      r_step  <= 1'b0;
      r_ud    <= UD_UP;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_step  <= w_step_nx;
      r_ud    <= w_ud_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = 1'b0;
    w_ud_nx    = r_ud;
    w_cur      = r_state;
    w_d        = UD_UP;
    w_err_nx   = (w_mode == MODE_PP) && (lo_lim >= hi_lim);

    if (!sw_run || (w_mode == MODE_HOLD)) begin
      w_state_nx = STOP;
    end else if (r_state == STOP) begin
      w_state_nx = (w_mode == MODE_DN) ? DOWN : UP;
    end else if (!r_err) begin
      // a flip in the tick cycle feeds the flipped direction into the bound check
      if ((w_mode == MODE_PP) && btn_flip)
        w_cur = (r_state == UP) ? DOWN : UP;
      case (w_mode)
        MODE_UP: w_d = UD_UP;
        MODE_DN: w_d = UD_DN;
        default: begin
          if (w_cur == UP) w_d = (q >= hi_lim) ? UD_DN : UD_UP;
          else             w_d = (q <= lo_lim) ? UD_UP : UD_DN;
        end
      endcase
      w_state_nx = w_cur;
      if (w_tick) begin
        w_step_nx  = 1'b1;
        w_ud_nx    = w_d;
        w_state_nx = (w_d == UD_DN) ? DOWN : UP;
      end
    end
  end

  assign step  = r_step;
  assign ud    = r_ud;
  assign state = r_state;
  assign tick  = w_tick;
  assign err   = r_err;

endmodule

// File: tb/tb_dem8bit_ctrl.sv
// Self-checking bench for dem8bit_ctrl with a behavioural up/down counter datapath.
module tb_dem8bit_ctrl;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       reset, sw_run, btn_flip, step, ud, tick, err, dp_load;
  logic [1:0] sw_mode, state;
  logic [7:0] lo_lim, hi_lim, q, dp_val;

  int total = 0;
  int bad   = 0;

  // reference model: state 0=STOP 1=UP 2=DOWN; runlen = consecutive run cycles
  int m_state, m_runlen;
  bit m_step, m_ud, m_tick, m_err;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (dp_load)   q <= dp_val;
    else if (step) q <= ud ? q - 8'd1 : q + 8'd1;
  end

  dem8bit_ctrl #(
    .CLK_HZ (8),
    .TICK_HZ(1),
    .N      (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_run  (sw_run),
    .sw_mode (sw_mode),
    .btn_flip(btn_flip),
    .lo_lim  (lo_lim),
    .hi_lim  (hi_lim),
    .q       (q),
    .step    (step),
    .ud      (ud),
    .state   (state),
    .tick    (tick),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_state));
    chk("step", 32'(step), 32'(m_step));
    chk("ud", 32'(ud), 32'(m_ud));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // predict from pre-edge inputs, advance one clock, then compare
  task automatic cyc();
    int ns, cur, nrun;
    bit nstep, nud, nerr, d;
    ns = m_state; nstep = 0; nud = m_ud; nerr = 0; nrun = 0;
    if (reset) begin
      ns = 0; nud = 0;
    end else begin
      nerr = (sw_mode == 2'b10) && (lo_lim >= hi_lim);
      nrun = sw_run ? m_runlen + 1 : 0;
      if (!sw_run || sw_mode == 2'b11) ns = 0;
      else if (m_state == 0) ns = (sw_mode == 2'b01) ? 2 : 1;
      else if (!m_err) begin
        cur = (sw_mode == 2'b10 && btn_flip) ? 3 - m_state : m_state;
        ns = cur;
        if (m_tick) begin
          if (sw_mode == 2'b00)      d = 0;
          else if (sw_mode == 2'b01) d = 1;
          else if (cur == 1)         d = (q >= hi_lim);
          else                       d = !(q <= lo_lim);
          nstep = 1; nud = d; ns = d ? 2 : 1;
        end
      end
    end
    @(posedge clk); #1;
    m_state = ns; m_step = nstep; m_ud = nud; m_err = nerr;
    m_runlen = nrun;
    m_tick = (nrun % DIV == DIV - 1);
    compare_all();
  endtask

  task automatic hit_reset();
    reset = 1'b1; #1;
    m_state = 0; m_step = 0; m_ud = 0; m_tick = 0; m_err = 0; m_runlen = 0;
    compare_all();
  endtask

  task automatic wait_step(output int n);
    n = 0;
    for (int i = 1; i <= 3 * DIV; i++) begin
      cyc();
      if (step) begin n = i; return; end
    end
  endtask

  task automatic wait_tick(output bit found);
    found = 0;
    for (int i = 1; i <= 3 * DIV; i++) begin
      cyc();
      if (tick) begin found = 1; return; end
    end
  endtask

  initial begin
    int n_tick, n_step, n, nst;
    bit first_ud, found, prev;
    logic [7:0] seq[$];
    logic [7:0] exp_seq[10];

    reset = 1; sw_run = 0; sw_mode = 2'b00; btn_flip = 0;
    lo_lim = 0; hi_lim = 0; dp_load = 1; dp_val = 0;
    m_state = 0; m_runlen = 0; m_step = 0; m_ud = 0; m_tick = 0; m_err = 0;
    #1 compare_all();
    cyc(); cyc();

    // first tick/step after reset release, then wrap 255->0
    dp_load = 0; sw_run = 1; reset = 0;
    n_tick = 0; n_step = 0; first_ud = 1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick && n_tick == 0) n_tick = i;
      if (step) begin n_step = i; first_ud = ud; break; end
    end
    chk("first_tick_edge", 32'(n_tick), 32'(DIV - 1));
    chk("first_step_edge", 32'(n_step), 32'(DIV));
    chk("first_ud", 32'(first_ud), 32'd0);
    cyc();
    chk("q_after_first", 32'(q), 32'd1);
    dp_val = 8'd255; dp_load = 1; cyc(); dp_load = 0;
    wait_step(n);
    cyc();
    chk("wrap_q", 32'(q), 32'd0);

    // ping-pong 3..6 from q=0
    sw_run = 0; cyc();
    sw_mode = 2'b10; lo_lim = 3; hi_lim = 6; dp_val = 0; dp_load = 1; cyc();
    dp_load = 0; sw_run = 1;
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3, 8'd4};
    prev = 0;
    for (int i = 0; i < 200 && seq.size() < 10; i++) begin
      cyc();
      if (prev) seq.push_back(q);
      prev = step;
    end
    chk("pp_count", 32'(seq.size()), 32'd10);
    for (int j = 0; j < 10 && j < seq.size(); j++) chk("pp_seq", 32'(seq[j]), 32'(exp_seq[j]));

    // flip while UP at q=4, coincident with a tick
    sw_run = 0; cyc();
    dp_val = 4; dp_load = 1; cyc();
    dp_load = 0; sw_run = 1;
    wait_tick(found);
    chk("flip_tick_found", 32'(found), 32'd1);
    btn_flip = 1; cyc(); btn_flip = 0;
    chk("flip_step", 32'(step), 32'd1);
    chk("flip_ud", 32'(ud), 32'd1);
    cyc();
    chk("flip_q", 32'(q), 32'd3);

    // drop sw_run mid-count, then re-raise
    sw_mode = 2'b00; cyc(); cyc(); cyc();
    sw_run = 0; cyc();
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_tick", 32'(tick), 32'd0);
    nst = 0;
    repeat (12) begin cyc(); if (step) nst++; end
    chk("stop_no_step", 32'(nst), 32'd0);
    sw_run = 1;
    wait_step(n);
    chk("rerun_step_edge", 32'(n), 32'(DIV));

    // error: lo >= hi in ping-pong
    sw_mode = 2'b10; lo_lim = 6; hi_lim = 6; cyc();
    chk("err_set", 32'(err), 32'd1);
    nst = 0;
    repeat (40) begin cyc(); if (step) nst++; end
    chk("err_no_step", 32'(nst), 32'd0);
    lo_lim = 2; cyc();
    chk("err_clear", 32'(err), 32'd0);
    wait_step(n);
    chk("err_resume", 32'(n > 0), 32'd1);

    // reset asserted one cycle before a pending step
    sw_mode = 2'b00;
    wait_tick(found);
    chk("rst_tick_found", 32'(found), 32'd1);
    hit_reset();
    cyc();
    chk("rst_no_step", 32'(step), 32'd0);
    reset = 0;

    // randomized traffic against the model
    sw_mode = 2'b10; lo_lim = 10; hi_lim = 40; sw_run = 1;
    for (int i = 0; i < 1500; i++) begin
      reset   = 0;
      sw_run  = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 23) == 0) sw_mode = 2'($urandom_range(0, 3));
      btn_flip = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 63) == 0) begin
        lo_lim = 8'($urandom_range(0, 127));
        hi_lim = 8'($urandom_range(0, 255));
      end
      dp_load = ($urandom_range(0, 99) == 0);
      dp_val  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) hit_reset();
      cyc();
    end
    reset = 0; btn_flip = 0; dp_load = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
